// File: rtl/gain_sched_pkg.sv
// Shared constants and helpers for the gain scheduler.
package gain_sched_pkg;

  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_IW    = 16;
  localparam int unsigned DEF_GW    = 16;
  localparam int unsigned DEF_GFRAC = 12;
  localparam int unsigned DEF_OW    = 12;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  // 1.0 in the default Q4.12 gain format
  localparam logic [DEF_GW-1:0] UNITY_GAIN = DEF_GW'(1) << DEF_GFRAC;

  // Saturating counter increment, holds at CNT_MAX
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gain_sched_sat.sv
// Signed saturation of an isz-bit value down to osz bits.
module gain_sched_sat #(
  parameter int unsigned isz  = 20,
  parameter int unsigned osz  = 12,
  parameter int unsigned warn = 0
) (
  input  logic signed [isz-1:0] din,
  output logic signed [osz-1:0] dout_c,
  output logic                  hit_c
);

  localparam logic signed [osz-1:0] MAXV = {1'b0, {(osz-1){1'b1}}};
  localparam logic signed [osz-1:0] MINV = {1'b1, {(osz-1){1'b0}}};

  // Sign bit plus all bits dropped by the narrowing must agree to be in range
  logic [isz-osz:0] hi_bits;
  logic             pos_ovf;
  logic             neg_ovf;

  assign hi_bits = din[isz-1:osz-1];
  assign pos_ovf = !din[isz-1] && (|hi_bits);
  assign neg_ovf = din[isz-1] && !(&hi_bits);
  assign hit_c   = pos_ovf | neg_ovf;

  // Clamp to the output range
  always_comb begin
    dout_c = din[osz-1:0];
    if (pos_ovf) begin
      dout_c = MAXV;
    end else if (neg_ovf) begin
      dout_c = MINV;
    end
  end

  // Optional simulation check that flags any clipping
  if (warn != 0) begin : g_warn
    always_comb begin
      assert (!hit_c);
    end
  end

endmodule

// File: rtl/gain_sched.sv
// Round-robin multi-channel sample scaler with per-channel gain and
// saturation event counters; two-stage pipeline, one sample per cycle.
module gain_sched
  import gain_sched_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned IW    = DEF_IW,
  parameter int unsigned GW    = DEF_GW,
  parameter int unsigned GFRAC = DEF_GFRAC,
  parameter int unsigned OW    = DEF_OW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH*IW-1:0]          in_data,
  input  logic [NCH-1:0]             in_valid,
  output logic [NCH-1:0]             in_ready,
  input  logic                       cfg_we,
  input  logic [$clog2(NCH)-1:0]     cfg_addr,
  input  logic [GW-1:0]              cfg_data,
  input  logic                       sat_clr,
  output logic [OW-1:0]              out_data,
  output logic [$clog2(NCH)-1:0]     out_chan,
  output logic                       out_valid,
  output logic [NCH*CNT_W-1:0]       sat_cnt,
  output logic [NCH-1:0]             sat_flag
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned PW = IW + GW;
  localparam int unsigned SW = PW - GFRAC;
  localparam logic [GW-1:0] UNITY = GW'(1) << GFRAC;

  logic [GW-1:0]        gain_q [NCH];
  logic [CW-1:0]        rr_ptr_q;
  logic                 gnt_any_c;
  logic [CW-1:0]        gnt_idx_c;

  logic                 s1_valid;
  logic signed [IW-1:0] s1_data;
  logic signed [GW-1:0] s1_gain;
  logic [CW-1:0]        s1_chan;

  logic signed [PW-1:0] prod_c;
  logic signed [SW-1:0] shft_c;
  logic signed [OW-1:0] sat_data_c;
  logic                 sat_hit_c;

  logic [CNT_W-1:0]     cnt_q [NCH];
  logic [CNT_W-1:0]     cnt_d [NCH];
  logic [NCH-1:0]       flag_d;

  // Round-robin search: first valid channel at or after the pointer, with wrap
  always_comb begin
    logic [CW-1:0] idx;
    idx       = '0;
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = rr_ptr_q + CW'(k);
      if (!gnt_any_c && in_valid[idx]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = idx;
      end
    end
  end

  // One-hot accept strobe, forced low during reset
  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_any_c) begin
      in_ready[gnt_idx_c] = 1'b1;
    end
  end

  // Arbiter pointer and gain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        gain_q[k] <= UNITY;
      end
    end else begin
      if (gnt_any_c) begin
        rr_ptr_q <= gnt_idx_c + CW'(1);
      end
      if (cfg_we) begin
        gain_q[cfg_addr] <= cfg_data;
      end
    end
  end

  // Stage 1: capture granted sample with the gain in effect before any same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_gain  <= '0;
      s1_chan  <= '0;
    end else begin
      s1_valid <= gnt_any_c;
      if (gnt_any_c) begin
        s1_data <= in_data[IW*int'(gnt_idx_c) +: IW];
        s1_gain <= gain_q[gnt_idx_c];
        s1_chan <= gnt_idx_c;
      end
    end
  end

  // Full-precision product; dropping the low GFRAC bits is a floor shift
  assign prod_c = PW'(s1_data) * PW'(s1_gain);
  assign shft_c = prod_c[PW-1:GFRAC];

  gain_sched_sat #(
    .isz  (SW),
    .osz  (OW),
    .warn (0)
  ) sat (
    .din    (shft_c),
    .dout_c (sat_data_c),
    .hit_c  (sat_hit_c)
  );

  // Stage 2: output register, holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data_c;
        out_chan <= s1_chan;
      end
    end
  end

  // Counter next state: clear dominates, increment lands with out_valid
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sat_clr) begin
        cnt_d[i] = '0;
      end else if (s1_valid && sat_hit_c && (s1_chan == CW'(i))) begin
        cnt_d[i] = cnt_inc(cnt_q[i]);
      end
      flag_d[i] = |cnt_d[i];
    end
  end

  // Saturation counters and nonzero flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      sat_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sat_flag <= flag_d;
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    sat_cnt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sat_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_gain_sched.sv
// Self-checking bench for gain_sched: directed table, corner sequences, random traffic.
module tb_gain_sched;
  import gain_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        sat_clr;
  logic [11:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic [31:0] sat_cnt;
  logic [3:0]  sat_flag;

  always #5 clk = ~clk;

  gain_sched dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sat_clr(sat_clr), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .sat_cnt(sat_cnt),
    .sat_flag(sat_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_ptr;
  int m_gain [4];
  int m_cnt  [4];
  bit m1_v;
  int m1_od;
  int m1_ch;
  bit m1_sat;
  bit m_ov;
  int m_od;
  int m_oc;
  logic [3:0] last_ready;

  typedef struct {
    logic [3:0] v;
    logic [3:0] rdy;
    bit         ov;
    int         od;
    int         oc;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_grant(input logic [3:0] v, input int ptr);
    for (int off = 0; off < 4; off++) begin
      if (v[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  // floor(sample*gain / 4096) clamped to the 12-bit signed range
  function automatic int scale(input int samp, input int gain, output bit sat);
    longint p;
    longint q;
    p = longint'(samp) * longint'(gain);
    q = p / 4096;
    if ((p < 0) && (p % 4096 != 0)) q = q - 1;
    sat = 1'b0;
    if (q > 2047) begin
      sat = 1'b1;
      return 2047;
    end
    if (q < -2048) begin
      sat = 1'b1;
      return -2048;
    end
    return int'(q);
  endfunction

  function automatic logic [63:0] mkd(input int ch, input int val);
    logic [63:0] d;
    d = '0;
    d[ch*16 +: 16] = 16'(val);
    return d;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      m_gain[i] = int'(UNITY_GAIN);
      m_cnt[i]  = 0;
    end
    m1_v = 1'b0;
    m_ov = 1'b0;
    m_od = 0;
    m_oc = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data", int'($signed(out_data)), m_od);
    chk("out_chan", int'(out_chan), m_oc);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sat_cnt%0d", i), int'(sat_cnt[i*8 +: 8]), m_cnt[i]);
      chk($sformatf("sat_flag%0d", i), int'(sat_flag[i]), int'(m_cnt[i] != 0));
    end
  endtask

  task automatic cycle(input logic [3:0] v, input logic [63:0] d,
                       input bit we = 1'b0, input int addr = 0,
                       input int gd = 0, input bit clr = 1'b0);
    int g;
    int samp;
    bit s;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    cfg_we   = we;
    cfg_addr = 2'(addr);
    cfg_data = 16'(gd);
    sat_clr  = clr;
    #1;
    g = ref_grant(v, m_ptr);
    last_ready = in_ready;
    chk("in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    if (m1_v) begin
      m_ov = 1'b1;
      m_od = m1_od;
      m_oc = m1_ch;
      if (m1_sat && m_cnt[m1_ch] < 255) m_cnt[m1_ch]++;
    end else begin
      m_ov = 1'b0;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    if (g >= 0) begin
      samp   = int'($signed(d[g*16 +: 16]));
      m1_od  = scale(samp, m_gain[g], s);
      m1_sat = s;
      m1_ch  = g;
      m1_v   = 1'b1;
      m_ptr  = (g + 1) % 4;
    end else begin
      m1_v = 1'b0;
    end
    if (we) m_gain[addr] = int'($signed(16'(gd)));
    #1;
    check_outputs();
  endtask

  initial begin
    logic [63:0] tdata;
    logic [63:0] rd;
    tdata = {16'sd400, 16'sd300, 16'sd200, 16'sd100};

    tv[0]  = '{4'hF, 4'h1, 1'b0, 0,   0};
    tv[1]  = '{4'hF, 4'h2, 1'b1, 100, 0};
    tv[2]  = '{4'hF, 4'h4, 1'b1, 200, 1};
    tv[3]  = '{4'hF, 4'h8, 1'b1, 300, 2};
    tv[4]  = '{4'hF, 4'h1, 1'b1, 400, 3};
    tv[5]  = '{4'hF, 4'h2, 1'b1, 100, 0};
    tv[6]  = '{4'hF, 4'h4, 1'b1, 200, 1};
    tv[7]  = '{4'hF, 4'h8, 1'b1, 300, 2};
    tv[8]  = '{4'h0, 4'h0, 1'b1, 400, 3};
    tv[9]  = '{4'h0, 4'h0, 1'b0, 0,   0};
    tv[10] = '{4'h1, 4'h1, 1'b0, 0,   0};
    tv[11] = '{4'h0, 4'h0, 1'b1, 100, 0};
    tv[12] = '{4'h0, 4'h0, 1'b0, 0,   0};

    // Reset with every channel requesting: no accepts allowed
    rst_n    = 1'b0;
    in_valid = 4'hF;
    in_data  = tdata;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    sat_clr  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", int'(in_ready), 0);
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    #1;
    check_outputs();

    // Directed table: round-robin order, latency, unity-gain passthrough
    for (int r = 0; r < 13; r++) begin
      cycle(tv[r].v, tdata);
      chk($sformatf("tbl%0d_ready", r), int'(last_ready), int'(tv[r].rdy));
      chk($sformatf("tbl%0d_ovalid", r), int'(out_valid), int'(tv[r].ov));
      if (tv[r].ov) begin
        chk($sformatf("tbl%0d_odata", r), int'($signed(out_data)), tv[r].od);
        chk($sformatf("tbl%0d_ochan", r), int'(out_chan), tv[r].oc);
      end
    end

    // Gain 4.0 on ch2 clips both ways
    cycle(4'h0, 64'h0, 1'b1, 2, 16'h4000);
    cycle(4'h4, mkd(2, 1000));
    cycle(4'h4, mkd(2, -1000));
    chk("sat_pos_data", int'($signed(out_data)), 2047);
    chk("sat_pos_cnt2", int'(sat_cnt[23:16]), 1);
    chk("sat_pos_flag2", int'(sat_flag[2]), 1);
    cycle(4'h0, 64'h0);
    chk("sat_neg_data", int'($signed(out_data)), -2048);
    chk("sat_neg_cnt2", int'(sat_cnt[23:16]), 2);

    // Same-cycle gain write uses old gain for that transfer
    cycle(4'h8, mkd(3, 64), 1'b1, 3, 16'h0800);
    cycle(4'h8, mkd(3, 64));
    chk("wr_old_gain", int'($signed(out_data)), 64);
    chk("wr_old_chan", int'(out_chan), 3);
    cycle(4'h0, 64'h0);
    chk("wr_new_gain", int'($signed(out_data)), 32);

    // Counter sticks at 255, clear beats a coincident increment
    for (int i = 0; i < 300; i++) cycle(4'h2, mkd(1, 32767));
    cycle(4'h0, 64'h0);
    chk("cnt1_cap", int'(sat_cnt[15:8]), 255);
    cycle(4'h2, mkd(1, -32768));
    cycle(4'h0, 64'h0, 1'b0, 0, 0, 1'b1);
    chk("clr_ovalid", int'(out_valid), 1);
    chk("clr_cnt1", int'(sat_cnt[15:8]), 0);
    chk("clr_flag1", int'(sat_flag[1]), 0);

    // Reset with samples in the pipeline
    cycle(4'h1, mkd(0, 5));
    cycle(4'h2, mkd(1, 7));
    @(negedge clk);
    in_valid = 4'hF;
    rst_n    = 1'b0;
    #1;
    chk("rst_ovalid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(4'h0, 64'h0);
      chk($sformatf("post_rst_ov%0d", i), int'(out_valid), 0);
    end
    cycle(4'h8, mkd(3, 64));
    cycle(4'h0, 64'h0);
    chk("rst_gain3", int'($signed(out_data)), 64);
    cycle(4'h4, mkd(2, 1000));
    cycle(4'h0, 64'h0);
    chk("rst_gain2", int'($signed(out_data)), 1000);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        for (int c = 0; c < 4; c++) rd[c*16 +: 16] = 16'($urandom_range(0, 4000)) - 16'd2000;
      end
      cycle(4'($urandom), rd,
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 24576)) - 12288,
            ($urandom_range(0, 31) == 0));
    end
    cycle(4'h0, 64'h0);
    cycle(4'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gain_sched.md
GAIN_SCHED -- requirements
Module: gain_sched

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (power of 2).
REQ-002 Parameter IW, default 16, signed input sample width.
REQ-003 Parameter GW, default 16, signed gain width, Q(GW-GFRAC).GFRAC format.
REQ-004 Parameter GFRAC, default 12, gain fractional bits.
REQ-005 Parameter OW, default 12, signed output sample width.
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port in_data, input, NCH*IW, channel i sample at bits [i*IW +: IW].
REQ-009 Port in_valid, input, NCH, per-channel sample valid.
REQ-010 Port in_ready, output, NCH, per-channel accept strobe.
REQ-011 Port cfg_we, input, 1, gain register write strobe.
REQ-012 Port cfg_addr, input, log2(NCH), gain register index.
REQ-013 Port cfg_data, input, GW, gain value written.
REQ-014 Port sat_clr, input, 1, clears all saturation counters.
REQ-015 Port out_data, output, OW, scaled, saturated sample.
REQ-016 Port out_chan, output, log2(NCH), channel of out_data.
REQ-017 Port out_valid, output, 1, out_data/out_chan qualifier, one-cycle pulse per sample.
REQ-018 Port sat_cnt, output, NCH*8, per-channel saturation event counters.
REQ-019 Port sat_flag, output, NCH, channel i counter nonzero.

Function
REQ-020 Transfer on channel i occurs in a cycle where in_valid[i] and in_ready[i] are both high.
REQ-021 At most one in_ready bit high per cycle; in_ready[i] high only if in_valid[i] high (combinational from in_valid and pointer).
REQ-022 Round-robin: grant the first valid channel at or after rr_ptr, searching upward with wrap; after a grant to k, rr_ptr becomes (k+1) mod NCH; no grant leaves rr_ptr unchanged.
REQ-023 Stage 1 (grant cycle +1): register sample, channel, gain[channel]; stage 2 (+2): register product output.
REQ-024 Latency: out_valid asserted exactly 2 cycles after a transfer; full throughput of one sample per cycle, no output backpressure.
REQ-025 Product = sample * gain, full IW+GW signed; arithmetic shift right GFRAC (truncate toward minus infinity), keep IW+GW-GFRAC bits.
REQ-026 Shifted product saturated to OW bits: above 2^(OW-1)-1 -> 2^(OW-1)-1; below -2^(OW-1) -> -2^(OW-1); else low OW bits pass.
REQ-027 Saturation event on a sample increments sat_cnt[chan] in the out_valid cycle; counter holds at 255.
REQ-028 sat_clr zeroes all counters next edge; clear wins over a simultaneous increment.
REQ-029 Gain write updates gain[cfg_addr] next edge; a transfer in the write cycle on that channel uses the old gain.
REQ-030 out_data/out_chan hold last value when out_valid low.

Reset
REQ-031 rst_n low asynchronously forces: gains to 1.0 (1<<GFRAC), rr_ptr 0, pipeline valids 0, out_valid 0, out_data 0, out_chan 0, sat_cnt 0.
REQ-032 Reset mid-stream discards in-flight samples; no out_valid for them after release.
REQ-033 in_ready is 0 while rst_n low.

Structure
REQ-034 Shared package holds NCH, widths, GFRAC, unity-gain constant, counter max (255).
REQ-035 Saturation done by one sub-module instance, sat (isz=IW+GW-GFRAC, osz=OW, warn=0).
REQ-036 Arbiter is a function or inline logic in gain_sched, not a separate module.

Verification
REQ-037 Reset defaults, ch0 sample 100, gain 0x1000 -> out_data 100, out_chan 0, 2 cycles after transfer.
REQ-038 All 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; out_valid high each cycle after latency.
REQ-039 ch2 gain 0x4000 (4.0), sample 1000 -> out_data 2047, sat_cnt[2]=1, sat_flag[2]=1; sample -1000 -> -2048, count 2.
REQ-040 300 saturating samples on ch1 -> sat_cnt[1] stops at 255; sat_clr coincident with saturation -> 0.
REQ-041 Gain write ch3=0x0800 in same cycle as ch3 transfer of 64 -> output 64; next ch3 sample 64 -> 32.
REQ-042 rst_n low with 2 samples in flight -> no out_valid after release; gains back to 0x1000.
